result_display: RTL

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/display_pkg.sv | 43 ++++
 rtl/bin2bcd_seq.sv | 53 +++++
 rtl/result_display.sv | 136 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the four-digit result display: digit codes,
// display register layout, control FSM states and the seven-segment table.
package display_pkg;

    localparam int DIGITS = 4;

    typedef logic [3:0] digit_t;

    localparam digit_t BLANK = 4'hA;
    localparam digit_t MINUS = 4'hB;
    localparam digit_t DASH  = 4'hC;

    // Index 0 is the units position (A4), index DIGITS-1 the thousands (A1).
    typedef digit_t [DIGITS-1:0] disp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHOW
    } state_t;

    // Active-low segment pattern ordered {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_of(input digit_t code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b000_0001;
            4'd1:    seg = 7'b100_1111;
            4'd2:    seg = 7'b001_0010;
            4'd3:    seg = 7'b000_0110;
            4'd4:    seg = 7'b100_1100;
            4'd5:    seg = 7'b010_0100;
            4'd6:    seg = 7'b010_0000;
            4'd7:    seg = 7'b000_1111;
            4'd8:    seg = 7'b000_0000;
            4'd9:    seg = 7'b000_0100;
            MINUS:   seg = 7'b111_1110;
            DASH:    seg = 7'b111_1110;
            default: seg = 7'b111_1111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, MSB first,
// 16 shift cycles followed by a one-cycle done pulse with the result held.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    logic [35:0] shreg;
    logic [4:0]  step;

    function automatic logic [19:0] add3(input logic [19:0] d);
        logic [19:0] r;
        r = d;
        for (int i = 0; i < 5; i++) begin
            if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shreg <= '0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start && !busy) begin
            shreg <= {20'd0, bin};
            step  <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (busy) begin
            if (step == 5'd16) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                shreg <= {add3(shreg[35:16]), shreg[15:0]} << 1;
                step  <= step + 5'd1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign bcd = shreg[35:16];

endmodule

// File: rtl/result_display.sv
// Captures a signed ALU result, converts it to BCD and drives a multiplexed
// four-digit seven-segment display with sign, blanking and range-error dashes.
import display_pkg::*;

module result_display #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        load,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        dp,
    output logic        A1,
    output logic        A2,
    output logic        A3,
    output logic        A4
);

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    state_t             state, next_state;
    logic               accept, show_load;
    logic               neg;
    disp_t              disp;
    logic [15:0]        magnitude;
    logic               conv_busy, conv_done;
    logic [19:0]        conv_bcd;
    logic [15:0]        scan_cnt;
    logic [1:0]         scan_pos;
    logic [DIGITS-1:0]  anode_q;
    logic [6:0]         seg_q;

    // A ten-thousands digit, or a thousands digit under a minus sign, does not fit.
    function automatic disp_t format_result(input logic [19:0] bcd, input logic is_neg);
        disp_t r;
        int    msd;
        r = {DIGITS{BLANK}};
        if (bcd[19:16] != 4'd0 || (is_neg && bcd[15:12] != 4'd0)) begin
            r = {DIGITS{DASH}};
        end else begin
            msd = 0;
            for (int i = 1; i < DIGITS; i++) begin
                if (bcd[4*i +: 4] != 4'd0) msd = i;
            end
            for (int i = 0; i < DIGITS; i++) begin
                if (i <= msd) r[i] = bcd[4*i +: 4];
                else if (is_neg && i == msd + 1) r[i] = MINUS;
            end
        end
        return r;
    endfunction

    assign magnitude = value[15] ? (~value + 16'd1) : value;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= ST_IDLE;
        else       state <= next_state;
    end

    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (load) next_state = ST_CONV;
            ST_CONV: if (conv_done && !conv_busy) next_state = ST_SHOW;
            ST_SHOW: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_SHOW);
        accept    = (state == ST_IDLE) && load;
        show_load = (state == ST_CONV) && conv_done && !conv_busy;
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .clrn  (clrn),
        .start (accept),
        .bin   (magnitude),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // NOTE: the display register is reset, so the panel comes up blank instead
    // of showing whatever the flops powered up with.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            neg  <= 1'b0;
            disp <= {DIGITS{BLANK}};
        end else begin
            if (accept)    neg  <= value[15];
            if (show_load) disp <= format_result(conv_bcd, neg);
        end
    end

    // Anodes and segments share one register stage so they can never disagree.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            scan_cnt <= '0;
            scan_pos <= '0;
            anode_q  <= '1;
            seg_q    <= '1;
        end else begin
            anode_q <= ~(DIGITS'(1) << scan_pos);
            seg_q   <= seg_of(disp[scan_pos]);
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_pos <= scan_pos + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign dp = 1'b1;
    assign A1 = anode_q[3];
    assign A2 = anode_q[2];
    assign A3 = anode_q[1];
    assign A4 = anode_q[0];

endmodule
